pixel_enhance_stream: RTL and testbench

//  Streaming RGB pixel-enhancement engine: accepts one pixel per cycle on a valid/ready

---
 rtl/pixel_enhance_stream.sv | 235 +++++++++++++++++++++++
 tb/tb_pixel_enhance_stream.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_enhance_stream.sv
// pixel_enhance_stream
//   Streaming RGB enhancement engine. Accepts one {R,G,B} pixel per cycle on a valid/ready
//   input, applies a frame-latched operation (pass, invert, brightness, threshold) and emits
//   the result with sof/eol/eof markers on a valid/ready output. There are two register stages:
//   S1 holds pixel/markers/grey, and S2 is the output register.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   mode, sign, value,    operation select and operands, sampled with the sof pixel
//   threshold
//   in_valid/in_ready/in_data       input stream, {R,G,B} with R in MSBs
//   out_valid/out_ready/out_data    output stream
//   out_sof/out_eol/out_eof         frame/line markers qualified by out_valid
//   frame_cnt             frames delivered downstream (wraps)
//
// Optional feature (macro FRAME_STATS_EN)
//   stat_min/stat_max/stat_sum/stat_valid: per-frame grey statistics of output pixels,
//   published one cycle after the eof output handshake.
module pixel_enhance_stream #(
  parameter int unsigned WIDTH  = 256,
  parameter int unsigned HEIGHT = 256,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic                  sign,
  input  logic [DATA_W-1:0]     value,
  input  logic [DATA_W-1:0]     threshold,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3*DATA_W-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3*DATA_W-1:0]   out_data,
  output logic                  out_sof,
  output logic                  out_eol,
  output logic                  out_eof,
  output logic [CNT_W-1:0]      frame_cnt
`ifdef FRAME_STATS_EN
  ,
  output logic [DATA_W-1:0]     stat_min,
  output logic [DATA_W-1:0]     stat_max,
  output logic [DATA_W+2+$clog2(WIDTH*HEIGHT)-1:0] stat_sum,
  output logic                  stat_valid
`endif
);

  localparam int unsigned COL_W = $clog2(WIDTH);
  localparam int unsigned ROW_W = $clog2(HEIGHT);
  localparam logic [DATA_W-1:0] MAX = '1;

  // Global stall: both stages advance together whenever the output register can move.
  logic adv, in_fire, out_fire;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign in_fire  = in_valid && adv;
  assign out_fire = out_valid && out_ready;

  // Position counters and markers of the pixel currently offered on the input.
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic in_sof, in_eol, in_eof;
  assign in_sof = (col_q == '0) && (row_q == '0);
  assign in_eol = (col_q == COL_W'(WIDTH - 1));
  assign in_eof = in_eol && (row_q == ROW_W'(HEIGHT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else if (in_fire) begin
      if (in_eol) begin
        col_q <= '0;
        row_q <= in_eof ? '0 : row_q + ROW_W'(1);
      end else begin
        col_q <= col_q + COL_W'(1);
      end
    end
  end

  // Frame configuration: the sof pixel uses the live inputs, later pixels the latched copy.
  logic [1:0]        cfg_mode_q;
  logic              cfg_sign_q;
  logic [DATA_W-1:0] cfg_value_q, cfg_thr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_mode_q  <= '0;
      cfg_sign_q  <= 1'b0;
      cfg_value_q <= '0;
      cfg_thr_q   <= '0;
    end else if (in_fire && in_sof) begin
      cfg_mode_q  <= mode;
      cfg_sign_q  <= sign;
      cfg_value_q <= value;
      cfg_thr_q   <= threshold;
    end
  end

  // Grey level: channel sum needs two extra bits before the divide by three.
  logic [DATA_W+1:0] in_sum;
  assign in_sum = {2'b00, in_data[3*DATA_W-1 -: DATA_W]} + {2'b00, in_data[2*DATA_W-1 -: DATA_W]}
                + {2'b00, in_data[DATA_W-1:0]};

  // Stage 1
  logic                s1_valid, s1_sof, s1_eol, s1_eof, s1_sign;
  logic [3*DATA_W-1:0] s1_data;
  logic [DATA_W-1:0]   s1_grey, s1_value, s1_thr;
  logic [1:0]          s1_mode;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_eof   <= 1'b0;
      s1_grey  <= '0;
      s1_mode  <= '0;
      s1_sign  <= 1'b0;
      s1_value <= '0;
      s1_thr   <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_data  <= in_data;
      s1_sof   <= in_sof;
      s1_eol   <= in_eol;
      s1_eof   <= in_eof;
      s1_grey  <= DATA_W'(in_sum / (DATA_W + 2)'(3));
      s1_mode  <= in_sof ? mode      : cfg_mode_q;
      s1_sign  <= in_sof ? sign      : cfg_sign_q;
      s1_value <= in_sof ? value     : cfg_value_q;
      s1_thr   <= in_sof ? threshold : cfg_thr_q;
    end
  end

  // Operation applied ahead of the output register.
  logic [3*DATA_W-1:0] op_data;
  logic [DATA_W-1:0]   ch;
  logic [DATA_W:0]     ch_sum;

  always_comb begin
    op_data = s1_data;
    ch      = '0;
    ch_sum  = '0;
    case (s1_mode)
      2'd1: op_data = {3{MAX - s1_grey}};
      2'd2: begin
        for (int c = 0; c < 3; c++) begin
          ch = s1_data[c*DATA_W +: DATA_W];
          if (s1_sign) begin
            ch_sum = {1'b0, ch} + {1'b0, s1_value};
            op_data[c*DATA_W +: DATA_W] = ch_sum[DATA_W] ? MAX : ch_sum[DATA_W-1:0];
          end else begin
            op_data[c*DATA_W +: DATA_W] = (ch > s1_value) ? ch - s1_value : '0;
          end
        end
      end
      2'd3: op_data = (s1_grey > s1_thr) ? '1 : '0;
      default: ;
    endcase
  end

  // Stage 2 / output register; markers are forced low on bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid;
      out_data  <= op_data;
      out_sof   <= s1_valid && s1_sof;
      out_eol   <= s1_valid && s1_eol;
      out_eof   <= s1_valid && s1_eof;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (out_fire && out_eof) begin
      frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

`ifdef FRAME_STATS_EN
  localparam int unsigned STAT_W = DATA_W + 2 + $clog2(WIDTH * HEIGHT);

  logic [DATA_W+1:0] out_sum;
  logic [DATA_W-1:0] og, acc_min_q, acc_max_q, nxt_min, nxt_max;
  logic [STAT_W-1:0] acc_sum_q, nxt_sum;

  assign out_sum = {2'b00, out_data[3*DATA_W-1 -: DATA_W]}
                 + {2'b00, out_data[2*DATA_W-1 -: DATA_W]} + {2'b00, out_data[DATA_W-1:0]};
  assign og      = DATA_W'(out_sum / (DATA_W + 2)'(3));

  // The sof pixel restarts the accumulators instead of folding into the previous frame.
  always_comb begin
    nxt_min = (out_sof || og < acc_min_q) ? og : acc_min_q;
    nxt_max = (out_sof || og > acc_max_q) ? og : acc_max_q;
    nxt_sum = (out_sof ? '0 : acc_sum_q) + STAT_W'(og);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_min_q  <= MAX;
      acc_max_q  <= '0;
      acc_sum_q  <= '0;
      stat_min   <= MAX;
      stat_max   <= '0;
      stat_sum   <= '0;
      stat_valid <= 1'b0;
    end else begin
      stat_valid <= 1'b0;
      if (out_fire) begin
        acc_min_q <= nxt_min;
        acc_max_q <= nxt_max;
        acc_sum_q <= nxt_sum;
        if (out_eof) begin
          stat_min   <= nxt_min;
          stat_max   <= nxt_max;
          stat_sum   <= nxt_sum;
          stat_valid <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_pixel_enhance_stream.sv
module tb_pixel_enhance_stream;

  localparam int unsigned W = 4;
  localparam int unsigned H = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic        sign = 1'b0;
  logic [7:0]  value = 8'd0;
  logic [7:0]  threshold = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] out_data;
  logic        out_sof, out_eol, out_eof;
  logic [15:0] frame_cnt;
`ifdef FRAME_STATS_EN
  logic [7:0]  stat_min, stat_max;
  logic [12:0] stat_sum;
  logic        stat_valid;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] cap_data[$];
  logic        cap_sof[$];
  logic        cap_eol[$];
  logic        cap_eof[$];

  pixel_enhance_stream #(.WIDTH(W), .HEIGHT(H), .DATA_W(8), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .sign      (sign),
    .value     (value),
    .threshold (threshold),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .out_eof   (out_eof),
    .frame_cnt (frame_cnt)
`ifdef FRAME_STATS_EN
    ,
    .stat_min  (stat_min),
    .stat_max  (stat_max),
    .stat_sum  (stat_sum),
    .stat_valid(stat_valid)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after posedge, so a negedge sample shows the next edge's handshake.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      cap_data.push_back(out_data);
      cap_sof.push_back(out_sof);
      cap_eol.push_back(out_eol);
      cap_eof.push_back(out_eof);
    end
  end

  task automatic clear_caps();
    cap_data.delete();
    cap_sof.delete();
    cap_eol.delete();
    cap_eof.delete();
  endtask

  task automatic drain();
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    clear_caps();
  endtask

  task automatic send_px(input logic [23:0] d);
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) break;
      if (i == 49) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: in_ready stuck 0 for pixel %h", d);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_caps(input int n);
    for (int i = 0; i < 200 && cap_data.size() < n; i++) begin
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (cap_data.size() != n) begin
      n_fail++;
      $display("FAIL out_count: got %0d pixels, expected %0d", cap_data.size(), n);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_caps();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({out_valid, out_sof, out_eol, out_eof, out_data, frame_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b data=%h markers=%b%b%b cnt=%0d expected all 0",
               out_valid, out_data, out_sof, out_eol, out_eof, frame_cnt);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    reset = 1'b0;
    clear_caps();
  endtask

  // Pass-through, exact 2-register latency, marker positions on a 4x2 frame.
  task automatic test_pass();
    logic [23:0] px[8];
    px = '{24'h102030, 24'h405060, 24'h708090, 24'hA0B0C0,
           24'hD0E0F0, 24'h0F1E2D, 24'h3C4B5A, 24'h69788A};
    drain();
    mode = 2'd0;
    out_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin
        in_valid = 1'b1;
        in_data  = px[k];
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (k == 0) begin
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL pass_latency: out_valid=%b one edge after accept, expected 0", out_valid);
        end
      end else begin
        if (out_valid !== 1'b1 || out_data !== px[k-1] || out_sof !== (k == 1) ||
            out_eol !== ((k - 1) % 4 == 3) || out_eof !== (k == 8)) begin
          n_fail++;
          $display("FAIL pass_px%0d: valid=%b data=%h sof/eol/eof=%b%b%b expected 1 %h %b%b%b",
                   k - 1, out_valid, out_data, out_sof, out_eol, out_eof, px[k-1],
                   k == 1, (k - 1) % 4 == 3, k == 8);
        end
      end
    end
  endtask

  task automatic test_brightness();
    drain();
    mode = 2'd2;
    sign = 1'b1;
    value = 8'd100;
    send_px(24'hC83200);
    for (int i = 1; i < 8; i++) send_px(24'h000000);
    wait_caps(8);
    n_tests++;
    if (cap_data.size() > 1 && (cap_data[0] !== 24'hFF9664 || cap_data[1] !== 24'h646464)) begin
      n_fail++;
      $display("FAIL bright_add: got %h %h expected ff9664 646464", cap_data[0], cap_data[1]);
    end
    drain();
    sign = 1'b0;
    send_px(24'hC83200);
    for (int i = 1; i < 8; i++) send_px(24'hFFFFFF);
    wait_caps(8);
    n_tests++;
    if (cap_data.size() > 1 && (cap_data[0] !== 24'h640000 || cap_data[1] !== 24'h9B9B9B)) begin
      n_fail++;
      $display("FAIL bright_sub: got %h %h expected 640000 9b9b9b", cap_data[0], cap_data[1]);
    end
  endtask

  task automatic test_threshold();
    drain();
    mode = 2'd3;
    threshold = 8'd90;
    send_px(24'h5A5A5D);
    send_px(24'h5A5A5A);
    for (int i = 2; i < 8; i++) send_px(24'h000000);
    wait_caps(8);
    n_tests++;
    if (cap_data.size() > 1 && (cap_data[0] !== 24'hFFFFFF || cap_data[1] !== 24'h000000)) begin
      n_fail++;
      $display("FAIL threshold: got %h %h expected ffffff 000000", cap_data[0], cap_data[1]);
    end
  endtask

  // Invert with a 5-cycle output stall; pixel i is {30+3i,60,90} so grey=60+i, result 195-i.
  task automatic test_invert_stall();
    drain();
    mode = 2'd1;
    out_ready = 1'b0;
    send_px({8'(30), 8'd60, 8'd90});
    send_px({8'(33), 8'd60, 8'd90});
    in_valid = 1'b1;
    in_data  = {8'(36), 8'd60, 8'd90};
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 24'hC3C3C3 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold%0d: valid=%b data=%h in_ready=%b expected 1 c3c3c3 0",
                 j, out_valid, out_data, in_ready);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 2; i < 8; i++) send_px({8'(30 + 3 * i), 8'd60, 8'd90});
    wait_caps(8);
    for (int i = 0; i < 8 && i < cap_data.size(); i++) begin
      n_tests++;
      if (cap_data[i] !== {3{8'(195 - i)}}) begin
        n_fail++;
        $display("FAIL invert_px%0d: got %h expected %h", i, cap_data[i], {3{8'(195 - i)}});
      end
    end
  endtask

  task automatic test_mode_switch();
    drain();
    do_reset();
    n_tests++;
    if (frame_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL fcnt0: got %0d expected 0", frame_cnt);
    end
    mode = 2'd0;
    threshold = 8'd90;
    for (int i = 0; i < 4; i++) send_px(24'h5A5A5D);
    mode = 2'd3;
    for (int i = 4; i < 8; i++) send_px(24'h5A5A5D);
    wait_caps(8);
    for (int i = 0; i < 8 && i < cap_data.size(); i++) begin
      n_tests++;
      if (cap_data[i] !== 24'h5A5A5D) begin
        n_fail++;
        $display("FAIL switch_f1_px%0d: got %h expected 5a5a5d", i, cap_data[i]);
      end
    end
    n_tests++;
    if (frame_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL fcnt1: got %0d expected 1", frame_cnt);
    end
    clear_caps();
    for (int i = 0; i < 8; i++) send_px(24'h5A5A5D);
    wait_caps(8);
    n_tests++;
    if (cap_data.size() > 7 && (cap_data[0] !== 24'hFFFFFF || cap_data[7] !== 24'hFFFFFF)) begin
      n_fail++;
      $display("FAIL switch_f2: got %h %h expected ffffff ffffff", cap_data[0], cap_data[7]);
    end
    n_tests++;
    if (frame_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL fcnt2: got %0d expected 2", frame_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    drain();
    mode = 2'd0;
    for (int i = 0; i < 3; i++) send_px(24'h111111 * (i + 1));
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({out_valid, out_sof, out_eol, out_eof, out_data, frame_cnt} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: valid=%b data=%h cnt=%0d expected all 0",
               out_valid, out_data, frame_cnt);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_caps();
    send_px(24'hABCDEF);
    for (int i = 1; i < 8; i++) send_px(24'h010203);
    wait_caps(8);
    n_tests++;
    if (cap_data.size() > 7 && (cap_sof[0] !== 1'b1 || cap_data[0] !== 24'hABCDEF ||
        cap_eol[3] !== 1'b1 || cap_eof[7] !== 1'b1 || cap_eof[3] !== 1'b0)) begin
      n_fail++;
      $display("FAIL midreset_frame: sof0=%b data0=%h eol3=%b eof3=%b eof7=%b expected 1 abcdef 1 0 1",
               cap_sof[0], cap_data[0], cap_eol[3], cap_eof[3], cap_eof[7]);
    end
    n_tests++;
    if (frame_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL midreset_fcnt: got %0d expected 1", frame_cnt);
    end
  endtask

`ifdef FRAME_STATS_EN
  task automatic test_stats();
    bit seen;
    drain();
    mode = 2'd0;
    for (int i = 0; i < 8; i++) send_px(24'h808080);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = stat_valid;
    end
    n_tests++;
    if (!seen || stat_min !== 8'd128 || stat_max !== 8'd128 || stat_sum !== 13'd1024) begin
      n_fail++;
      $display("FAIL stats: valid=%b min=%0d max=%0d sum=%0d expected 1 128 128 1024",
               seen, stat_min, stat_max, stat_sum);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_pass();
    test_brightness();
    test_threshold();
    test_invert_stall();
    test_mode_switch();
    test_reset_midframe();
`ifdef FRAME_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
